// File: rtl/mem_access_stage_if.sv
// Data-bus bundle between the MEM stage (master) and the memory system (slave).
interface mem_access_stage_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  ram_en;
  logic                  ram_write_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [3:0]            ram_write_sel;
  logic [31:0]           ram_write_data;
  logic                  ram_ready;
  logic [31:0]           ram_read_data;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_sel, ram_write_data,
    input  ram_ready, ram_read_data
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_sel, ram_write_data,
    output ram_ready, ram_read_data
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues aligned load/store bus transactions, stalls until the
// bus answers (or times out) and forwards extended load data / write-back info.
module mem_access_stage #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_en_in,
  input  logic        ram_write_en_in,
  input  logic [5:0]  inst_op_in,
  input  logic [31:0] reg_data_2_in,
  input  logic [31:0] result_in,
  input  logic        write_reg_en_in,
  input  logic [4:0]  write_reg_addr_in,
  input  logic        write_hilo_en_in,
  input  logic [31:0] write_hi_data_in,
  input  logic [31:0] write_lo_data_in,
  mem_access_stage_if.master bus,
  output logic        mem_stall_request,
  output logic        mem_load_flag,
  output logic        addr_error,
  output logic        bus_error,
  output logic [31:0] result_out,
  output logic        write_reg_en_out,
  output logic [4:0]  write_reg_addr_out,
  output logic        write_hilo_en_out,
  output logic [31:0] write_hi_data_out,
  output logic [31:0] write_lo_data_out
);
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [7:0] C_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_bus_err;

  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_signed;
  logic        w_misaligned;
  logic        w_access;
  logic        w_store;
  logic        w_req;
  logic        w_stall;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Unknown opcodes fall through to word size, i.e. LW/SW.
  assign w_is_byte    = (inst_op_in == OP_LB) || (inst_op_in == OP_LBU) || (inst_op_in == OP_SB);
  assign w_is_half    = (inst_op_in == OP_LH) || (inst_op_in == OP_LHU) || (inst_op_in == OP_SH);
  assign w_is_signed  = (inst_op_in == OP_LB) || (inst_op_in == OP_LH);
  assign w_misaligned = ram_en_in & ((w_is_half & result_in[0]) |
                                     (~w_is_byte & ~w_is_half & (|result_in[1:0])));
  assign w_access     = ram_en_in & ~w_misaligned;
  assign w_store      = ram_en_in & ram_write_en_in;

  always_comb begin
    w_req   = 1'b0;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req   = w_access;
        w_stall = w_access;
      end
      S_WAIT: begin
        w_req   = 1'b1;
        w_stall = ~bus.ram_ready;
      end
      default: begin
        w_req   = 1'b0;
        w_stall = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_sel   = 4'b1111;
    w_wdata = reg_data_2_in;
    if (w_is_byte) begin
      w_sel   = 4'b0001 << result_in[1:0];
      w_wdata = {4{reg_data_2_in[7:0]}};
    end else if (w_is_half) begin
      w_sel   = result_in[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{reg_data_2_in[15:0]}};
    end
  end

  // DONE replays the word captured on the ready edge; the bus data is gone by then.
  assign w_word = (r_state == S_DONE) ? r_rdata : bus.ram_read_data;
  assign w_byte = w_word[{result_in[1:0], 3'b000} +: 8];
  assign w_half = result_in[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load = w_word;
    if (w_is_byte) begin
      w_load = {{24{w_is_signed & w_byte[7]}}, w_byte};
    end else if (w_is_half) begin
      w_load = {{16{w_is_signed & w_half[15]}}, w_half};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_cnt <= '0;
            if (bus.ram_ready) begin
              r_rdata <= bus.ram_read_data;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.ram_ready) begin
            r_rdata <= bus.ram_read_data;
            r_state <= S_DONE;
          end else if (r_cnt == C_LAST) begin
            r_bus_err <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Every output is forced low while reset is held, independent of the clock.
  assign bus.ram_en         = rst & w_req;
  assign bus.ram_write_en   = rst & w_req & ram_write_en_in;
  assign bus.ram_addr       = (rst & w_req) ? {result_in[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.ram_write_sel  = (rst & w_req & ram_write_en_in) ? w_sel : 4'b0000;
  assign bus.ram_write_data = (rst & w_req & ram_write_en_in) ? w_wdata : 32'h0;

  assign mem_stall_request  = rst & w_stall;
  assign mem_load_flag      = rst & ram_en_in & ~ram_write_en_in;
  assign addr_error         = rst & w_misaligned;
  assign bus_error          = rst & r_bus_err;
  assign result_out         = ~rst ? 32'h0 :
                              (w_access & ~ram_write_en_in) ? w_load : result_in;
  assign write_reg_en_out   = rst & write_reg_en_in & ~w_misaligned & ~w_store &
                              ~((r_state == S_DONE) & r_bus_err);
  assign write_reg_addr_out = rst ? write_reg_addr_in : 5'd0;
  assign write_hilo_en_out  = rst & write_hilo_en_in;
  assign write_hi_data_out  = rst ? write_hi_data_in : 32'h0;
  assign write_lo_data_out  = rst ? write_lo_data_in : 32'h0;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through, loads, stores, misalignment,
// bus timeout and asynchronous reset during an outstanding access.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        ram_en_in;
  logic        ram_write_en_in;
  logic [5:0]  inst_op_in;
  logic [31:0] reg_data_2_in;
  logic [31:0] result_in;
  logic        write_reg_en_in;
  logic [4:0]  write_reg_addr_in;
  logic        write_hilo_en_in;
  logic [31:0] write_hi_data_in;
  logic [31:0] write_lo_data_in;
  logic        mem_stall_request;
  logic        mem_load_flag;
  logic        addr_error;
  logic        bus_error;
  logic [31:0] result_out;
  logic        write_reg_en_out;
  logic [4:0]  write_reg_addr_out;
  logic        write_hilo_en_out;
  logic [31:0] write_hi_data_out;
  logic [31:0] write_lo_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_stage_if #(.ADDR_WIDTH(32)) bus_if ();

  mem_access_stage #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .ram_en_in          (ram_en_in),
    .ram_write_en_in    (ram_write_en_in),
    .inst_op_in         (inst_op_in),
    .reg_data_2_in      (reg_data_2_in),
    .result_in          (result_in),
    .write_reg_en_in    (write_reg_en_in),
    .write_reg_addr_in  (write_reg_addr_in),
    .write_hilo_en_in   (write_hilo_en_in),
    .write_hi_data_in   (write_hi_data_in),
    .write_lo_data_in   (write_lo_data_in),
    .bus                (bus_if),
    .mem_stall_request  (mem_stall_request),
    .mem_load_flag      (mem_load_flag),
    .addr_error         (addr_error),
    .bus_error          (bus_error),
    .result_out         (result_out),
    .write_reg_en_out   (write_reg_en_out),
    .write_reg_addr_out (write_reg_addr_out),
    .write_hilo_en_out  (write_hilo_en_out),
    .write_hi_data_out  (write_hi_data_out),
    .write_lo_data_out  (write_lo_data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ex(input logic en, input logic we, input logic [5:0] op,
                    input logic [31:0] d2, input logic [31:0] res,
                    input logic wren, input logic [4:0] wa);
    ram_en_in         = en;
    ram_write_en_in   = we;
    inst_op_in        = op;
    reg_data_2_in     = d2;
    result_in         = res;
    write_reg_en_in   = wren;
    write_reg_addr_in = wa;
  endtask

  task automatic bus_resp(input logic rdy, input logic [31:0] rd);
    bus_if.ram_ready     = rdy;
    bus_if.ram_read_data = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with an access pending on the inputs: everything must read 0
    rst              = 1'b0;
    write_hilo_en_in = 1'b1;
    write_hi_data_in = 32'hAAAA_5555;
    write_lo_data_in = 32'h1111_2222;
    ex(1'b1, 1'b0, 6'h23, 32'h0, 32'h0000_1234, 1'b1, 5'd3);
    bus_resp(1'b0, 32'h0);
    #2;
    check("rst_ram_en", 32'(bus_if.ram_en), 32'h0);
    check("rst_stall", 32'(mem_stall_request), 32'h0);
    check("rst_result", result_out, 32'h0);
    check("rst_wren", 32'(write_reg_en_out), 32'h0);
    check("rst_hi", write_hi_data_out, 32'h0);

    // ADDU pass-through
    next_cycle();
    rst = 1'b1;
    ex(1'b0, 1'b0, 6'h00, 32'h0, 32'h0000_1234, 1'b1, 5'd5);
    #1;
    check("addu_result", result_out, 32'h0000_1234);
    check("addu_wren", 32'(write_reg_en_out), 32'h1);
    check("addu_waddr", 32'(write_reg_addr_out), 32'h5);
    check("addu_stall", 32'(mem_stall_request), 32'h0);
    check("addu_ram_en", 32'(bus_if.ram_en), 32'h0);
    check("addu_hilo_en", 32'(write_hilo_en_out), 32'h1);
    check("addu_hi", write_hi_data_out, 32'hAAAA_5555);
    check("addu_lo", write_lo_data_out, 32'h1111_2222);

    // LB at 0x103, ready after two wait cycles
    next_cycle();
    ex(1'b1, 1'b0, 6'h20, 32'h0, 32'h0000_0103, 1'b1, 5'd8);
    bus_resp(1'b0, 32'h80FF_0011);
    #1;
    check("lb_ram_en", 32'(bus_if.ram_en), 32'h1);
    check("lb_addr", bus_if.ram_addr, 32'h0000_0100);
    check("lb_sel", 32'(bus_if.ram_write_sel), 32'h0);
    check("lb_stall_c1", 32'(mem_stall_request), 32'h1);
    check("lb_load_flag", 32'(mem_load_flag), 32'h1);
    next_cycle();
    check("lb_stall_c2", 32'(mem_stall_request), 32'h1);
    check("lb_wait_ram_en", 32'(bus_if.ram_en), 32'h1);
    next_cycle();
    check("lb_stall_c3", 32'(mem_stall_request), 32'h1);
    next_cycle();
    bus_resp(1'b1, 32'h80FF_0011);
    #1;
    check("lb_ready_stall", 32'(mem_stall_request), 32'h0);
    check("lb_ready_ram_en", 32'(bus_if.ram_en), 32'h1);
    check("lb_ready_result", result_out, 32'hFFFF_FF80);
    check("lb_ready_wren", 32'(write_reg_en_out), 32'h1);
    next_cycle();
    bus_resp(1'b0, 32'hDEAD_BEEF);
    #1;
    check("lb_done_ram_en", 32'(bus_if.ram_en), 32'h0);
    check("lb_done_stall", 32'(mem_stall_request), 32'h0);
    check("lb_done_result", result_out, 32'hFFFF_FF80);

    // LBU at 0x103, zero-wait
    next_cycle();
    ex(1'b1, 1'b0, 6'h24, 32'h0, 32'h0000_0103, 1'b1, 5'd8);
    bus_resp(1'b1, 32'h80FF_0011);
    #1;
    check("lbu_ram_en", 32'(bus_if.ram_en), 32'h1);
    check("lbu_stall", 32'(mem_stall_request), 32'h1);
    check("lbu_result", result_out, 32'h0000_0080);
    next_cycle();
    bus_resp(1'b0, 32'hDEAD_BEEF);
    #1;
    check("lbu_done_ram_en", 32'(bus_if.ram_en), 32'h0);
    check("lbu_done_result", result_out, 32'h0000_0080);

    // SH at 0x202, zero-wait
    next_cycle();
    ex(1'b1, 1'b1, 6'h29, 32'h0000_ABCD, 32'h0000_0202, 1'b1, 5'd9);
    bus_resp(1'b1, 32'h0);
    #1;
    check("sh_ram_en", 32'(bus_if.ram_en), 32'h1);
    check("sh_write_en", 32'(bus_if.ram_write_en), 32'h1);
    check("sh_addr", bus_if.ram_addr, 32'h0000_0200);
    check("sh_sel", 32'(bus_if.ram_write_sel), 32'hC);
    check("sh_wdata", bus_if.ram_write_data, 32'hABCD_ABCD);
    check("sh_wren", 32'(write_reg_en_out), 32'h0);
    check("sh_result", result_out, 32'h0000_0202);
    check("sh_load_flag", 32'(mem_load_flag), 32'h0);
    next_cycle();
    bus_resp(1'b0, 32'h0);
    #1;
    check("sh_done_ram_en", 32'(bus_if.ram_en), 32'h0);
    check("sh_done_stall", 32'(mem_stall_request), 32'h0);

    // LH at 0x102, zero-wait, upper halfword sign-extended
    next_cycle();
    ex(1'b1, 1'b0, 6'h21, 32'h0, 32'h0000_0102, 1'b1, 5'd10);
    bus_resp(1'b1, 32'h80FF_0011);
    #1;
    check("lh_result", result_out, 32'hFFFF_80FF);
    next_cycle();
    bus_resp(1'b0, 32'h0);
    #1;
    check("lh_done_result", result_out, 32'hFFFF_80FF);

    // SB at 0x001, zero-wait
    next_cycle();
    ex(1'b1, 1'b1, 6'h28, 32'h1234_56A5, 32'h0000_0001, 1'b0, 5'd0);
    bus_resp(1'b1, 32'h0);
    #1;
    check("sb_sel", 32'(bus_if.ram_write_sel), 32'h2);
    check("sb_wdata", bus_if.ram_write_data, 32'hA5A5_A5A5);
    next_cycle();
    bus_resp(1'b0, 32'h0);

    // Misaligned word and halfword
    next_cycle();
    ex(1'b1, 1'b0, 6'h23, 32'h0, 32'h0000_0305, 1'b1, 5'd11);
    #1;
    check("lw_mis_addr_error", 32'(addr_error), 32'h1);
    check("lw_mis_ram_en", 32'(bus_if.ram_en), 32'h0);
    check("lw_mis_wren", 32'(write_reg_en_out), 32'h0);
    check("lw_mis_stall", 32'(mem_stall_request), 32'h0);
    ex(1'b1, 1'b0, 6'h25, 32'h0, 32'h0000_0101, 1'b1, 5'd11);
    #1;
    check("lhu_mis_addr_error", 32'(addr_error), 32'h1);
    next_cycle();
    ex(1'b0, 1'b0, 6'h00, 32'h0, 32'h0000_0305, 1'b1, 5'd11);
    #1;
    check("mis_after_ram_en", 32'(bus_if.ram_en), 32'h0);
    check("mis_after_addr_error", 32'(addr_error), 32'h0);

    // LW timing out after four wait cycles
    next_cycle();
    ex(1'b1, 1'b0, 6'h23, 32'h0, 32'h0000_0400, 1'b1, 5'd12);
    bus_resp(1'b0, 32'h0);
    #1;
    check("to_idle_stall", 32'(mem_stall_request), 32'h1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      check("to_wait_stall", 32'(mem_stall_request), 32'h1);
      check("to_wait_bus_error", 32'(bus_error), 32'h0);
    end
    next_cycle();
    check("to_done_bus_error", 32'(bus_error), 32'h1);
    check("to_done_stall", 32'(mem_stall_request), 32'h0);
    check("to_done_ram_en", 32'(bus_if.ram_en), 32'h0);
    check("to_done_wren", 32'(write_reg_en_out), 32'h0);
    ex(1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 5'd0);
    next_cycle();
    check("to_after_bus_error", 32'(bus_error), 32'h0);
    check("to_after_stall", 32'(mem_stall_request), 32'h0);

    // Asynchronous reset while in WAIT, then SW to 0x0
    next_cycle();
    ex(1'b1, 1'b0, 6'h23, 32'h0, 32'h0000_0500, 1'b1, 5'd13);
    next_cycle();
    check("ar_wait_ram_en", 32'(bus_if.ram_en), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_ram_en", 32'(bus_if.ram_en), 32'h0);
    check("ar_stall", 32'(mem_stall_request), 32'h0);
    check("ar_result", result_out, 32'h0);
    check("ar_load_flag", 32'(mem_load_flag), 32'h0);
    check("ar_wren", 32'(write_reg_en_out), 32'h0);
    next_cycle();
    rst = 1'b1;
    ex(1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 5'd0);
    #1;
    check("ar_release_ram_en", 32'(bus_if.ram_en), 32'h0);
    next_cycle();
    ex(1'b1, 1'b1, 6'h2B, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 5'd0);
    #1;
    check("sw_ram_en", 32'(bus_if.ram_en), 32'h1);
    check("sw_stall", 32'(mem_stall_request), 32'h1);
    check("sw_sel", 32'(bus_if.ram_write_sel), 32'hF);
    check("sw_wdata", bus_if.ram_write_data, 32'hCAFE_F00D);
    next_cycle();
    bus_resp(1'b1, 32'h0);
    #1;
    check("sw_ready_stall", 32'(mem_stall_request), 32'h0);
    check("sw_ready_ram_en", 32'(bus_if.ram_en), 32'h1);
    next_cycle();
    bus_resp(1'b0, 32'h0);
    #1;
    check("sw_done_ram_en", 32'(bus_if.ram_en), 32'h0);
    check("sw_done_stall", 32'(mem_stall_request), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
